// File: rtl/tc_latency_ram.sv
// Single-port word RAM with programmable read/write latency, byte enables,
// busy/ready handshake and out-of-range flagging.
module tc_latency_ram #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    save,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    busy,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   out,
  output logic                    error
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CW-1:0]       RD_LAT  = CW'(READ_LATENCY);
  localparam logic [CW-1:0]       WR_LAT  = CW'(WRITE_LATENCY);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_reg;
  logic [CW-1:0]           cnt_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [NB-1:0]           be_reg;
  logic                    load_reg;
  logic                    save_reg;
  logic                    busy_reg;
  logic                    ready_reg;
  logic                    error_reg;
  logic [DATA_WIDTH-1:0]   out_reg;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_reg;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    in_range;
  logic                    commit;
  logic [IW-1:0]           acc_idx;
  logic [IW-1:0]           op_idx;

  assign in_range = {1'b0, addr_reg} < DEPTH_W;
  assign commit   = (state_reg == BUSY) && (cnt_reg == CW'(1));
  assign acc_idx  = address[IW-1:0];
  assign op_idx   = addr_reg[IW-1:0];

  // Old word is fetched at the accept edge; nothing else can write the
  // array while busy, so it is still current when the op completes.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = be_reg[gi] ? data_reg[gi*8 +: 8] : rd_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (state_reg == IDLE) begin
      rd_reg <= mem[acc_idx];
    end
    if (commit && save_reg && in_range) begin
      mem[op_idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      be_reg    <= '0;
      load_reg  <= 1'b0;
      save_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b0;
      error_reg <= 1'b0;
      out_reg   <= '0;
    end else begin
      ready_reg <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load || save) begin
            state_reg <= BUSY;
            busy_reg  <= 1'b1;
            cnt_reg   <= save ? WR_LAT : RD_LAT;
            addr_reg  <= address;
            data_reg  <= in;
            be_reg    <= byte_en;
            load_reg  <= load;
            save_reg  <= save;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - CW'(1);
          if (commit) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
            error_reg <= !in_range;
            if (load_reg) begin
              out_reg <= !in_range ? '0 : (save_reg ? merged : rd_reg);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy  = busy_reg;
  assign ready = ready_reg;
  assign out   = out_reg;
  assign error = error_reg;

endmodule
